bcd_serial_adder_ctrl: RTL and testbench

Digit-serial multi-digit BCD adder controller. Accepts two packed NDIG-digit BCD operands on a start pulse. Sequences them one digit per cycle, LSD first, through a single shared one-digit BCD adder with decimal correction, and registers the carry between digits. Presents the packed result, decimal carry-out and an invalid-digit flag with a done pulse; used wherever area matters more than latency in the BCD arithmetic path.

---
 rtl/bcd_serial_adder_ctrl_pkg.sv | 22 ++
 rtl/bcd_serial_adder_ctrl_digit_add.sv | 26 ++
 rtl/bcd_serial_adder_ctrl.sv | 166 ++++++++++++++++
 tb/tb_bcd_serial_adder_ctrl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/bcd_serial_adder_ctrl_pkg.sv
// Shared constants, state encoding and digit helpers for the digit-serial BCD adder.
package bcd_serial_adder_ctrl_pkg;

    localparam int         DIG_W    = 4;
    localparam logic [3:0] BCD_MAX  = 4'd9;
    localparam logic [3:0] BCD_CORR = 4'd6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic logic digit_invalid(input logic [3:0] d);
        return (d > BCD_MAX);
    endfunction

    function automatic logic [3:0] nines_comp(input logic [3:0] d);
        return (BCD_MAX - d);
    endfunction

endpackage

// File: rtl/bcd_serial_adder_ctrl_digit_add.sv
// One-digit BCD adder with decimal correction; the single shared resource of the serial adder.
module bcd_digit_add
    import bcd_serial_adder_ctrl_pkg::*;
(
    input  logic [3:0] a_d,
    input  logic [3:0] b_d,
    input  logic       c,
    output logic [3:0] digit,
    output logic       carry
);

    logic [4:0] raw_s;

    // Binary sum of the two digits plus carry, corrected by +6 when it leaves the decimal range.
    always_comb begin
        raw_s = {1'b0, a_d} + {1'b0, b_d} + {4'b0000, c};
        if (raw_s > {1'b0, BCD_MAX}) begin
            digit = raw_s[3:0] + BCD_CORR;
            carry = 1'b1;
        end else begin
            digit = raw_s[3:0];
            carry = 1'b0;
        end
    end

endmodule

// File: rtl/bcd_serial_adder_ctrl.sv
// Digit-serial NDIG-digit BCD adder controller (LSD first, one digit per cycle).
// Optional nines-complement subtraction is enabled by defining BCD_SUB_EN.
module bcd_serial_adder_ctrl
    import bcd_serial_adder_ctrl_pkg::*;
#(
    parameter int NDIG = 4
)(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [4*NDIG-1:0]     a,
    input  logic [4*NDIG-1:0]     b,
    input  logic                  cin,
`ifdef BCD_SUB_EN
    input  logic                  sub,
`endif
    output logic                  busy,
    output logic                  done,
    output logic [4*NDIG-1:0]     sum,
    output logic                  cout,
    output logic                  err
);

    localparam int W     = DIG_W * NDIG;
    localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;

    state_e             state_r;
    state_e             state_next_s;
    logic [IDX_W-1:0]   idx_r;
    logic [W-1:0]       a_r;
    logic [W-1:0]       b_r;
    logic [W-1:0]       sum_r;
    logic               carry_r;
    logic               cout_r;
    logic               err_r;
    logic               busy_r;
    logic               done_r;

    logic               load_s;
    logic               step_s;
    logic               last_s;
    logic [W-1:0]       b_load_s;
    logic               carry_load_s;
    logic               err_load_s;
    logic [3:0]         dig_s;
    logic               dig_carry_s;

    assign last_s = (idx_r == IDX_W'(NDIG - 1));

    // Operands shift right each step, so the adder always sees the current digit in the low nibble.
    bcd_digit_add u_digit_add (
        .a_d   (a_r[3:0]),
        .b_d   (b_r[3:0]),
        .c     (carry_r),
        .digit (dig_s),
        .carry (dig_carry_s)
    );

    // Next-state logic: start is honoured only from IDLE or DONE.
    always_comb begin
        state_next_s = state_r;
        load_s       = 1'b0;
        step_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    load_s       = 1'b1;
                    state_next_s = RUN;
                end else begin
                    state_next_s = IDLE;
                end
            end
            RUN: begin
                step_s = 1'b1;
                if (last_s) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = RUN;
                end
            end
            DONE: begin
                if (start) begin
                    load_s       = 1'b1;
                    state_next_s = RUN;
                end else begin
                    state_next_s = IDLE;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Load-time operand preparation: invalid-digit scan on the original inputs, optional complement of B.
    always_comb begin
        err_load_s   = 1'b0;
        b_load_s     = b;
        carry_load_s = cin;
        for (int i = 0; i < NDIG; i++) begin
            err_load_s = err_load_s | digit_invalid(a[i*DIG_W +: DIG_W])
                                    | digit_invalid(b[i*DIG_W +: DIG_W]);
        end
`ifdef BCD_SUB_EN
        if (sub) begin
            for (int i = 0; i < NDIG; i++) begin
                b_load_s[i*DIG_W +: DIG_W] = nines_comp(b[i*DIG_W +: DIG_W]);
            end
            carry_load_s = 1'b1;
        end else begin
            b_load_s     = b;
            carry_load_s = cin;
        end
`endif
    end

    // State register with registered status flags that track the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            busy_r  <= (state_next_s == RUN);
            done_r  <= (state_next_s == DONE);
        end
    end

    // Operand, carry, index and result registers; result digits enter from the top of sum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r     <= {W{1'b0}};
            b_r     <= {W{1'b0}};
            sum_r   <= {W{1'b0}};
            carry_r <= 1'b0;
            cout_r  <= 1'b0;
            err_r   <= 1'b0;
            idx_r   <= {IDX_W{1'b0}};
        end else if (load_s) begin
            a_r     <= a;
            b_r     <= b_load_s;
            sum_r   <= {W{1'b0}};
            carry_r <= carry_load_s;
            cout_r  <= 1'b0;
            err_r   <= err_load_s;
            idx_r   <= {IDX_W{1'b0}};
        end else if (step_s) begin
            a_r     <= a_r >> DIG_W;
            b_r     <= b_r >> DIG_W;
            sum_r   <= (sum_r >> DIG_W) | (W'(dig_s) << (W - DIG_W));
            carry_r <= dig_carry_s;
            idx_r   <= idx_r + IDX_W'(1);
            if (last_s) begin
                cout_r <= dig_carry_s;
            end
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign sum  = sum_r;
    assign cout = cout_r;
    assign err  = err_r;

endmodule

// File: tb/tb_bcd_serial_adder_ctrl.sv
// Directed scoreboard bench for bcd_serial_adder_ctrl (NDIG=4); covers BCD_SUB_EN when defined.
module tb_bcd_serial_adder_ctrl;

    localparam int NDIG = 4;
    localparam int W    = 4 * NDIG;
    localparam int MODV = 10000;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         cin   = 1'b0;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
`ifdef BCD_SUB_EN
    logic         sub   = 1'b0;
`endif
    logic         busy;
    logic         done;
    logic         cout;
    logic         err;
    logic [W-1:0] sum;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         err;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    bcd_serial_adder_ctrl #(.NDIG(NDIG)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
`ifdef BCD_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .err   (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic int bcd2int(input logic [W-1:0] v);
        int r = 0;
        for (int i = NDIG - 1; i >= 0; i--) r = r * 10 + int'(v[i*4 +: 4]);
        return r;
    endfunction

    function automatic logic [W-1:0] int2bcd(input int v);
        logic [W-1:0] r = '0;
        int t = v;
        for (int i = 0; i < NDIG; i++) begin
            r[i*4 +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic logic has_invalid(input logic [W-1:0] v);
        logic bad = 1'b0;
        for (int i = 0; i < NDIG; i++) bad = bad | (v[i*4 +: 4] > 4'd9);
        return bad;
    endfunction

    // Drives operands at a falling edge with start high and records the expected result.
    task automatic launch(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv, input logic sv);
        exp_t e;
        int   t;
        @(negedge clk);
        a     = av;
        b     = bv;
        cin   = cv;
`ifdef BCD_SUB_EN
        sub   = sv;
`endif
        start = 1'b1;
        if (sv) t = bcd2int(av) + (MODV - 1 - bcd2int(bv)) + 1;
        else    t = bcd2int(av) + bcd2int(bv) + int'(cv);
        e.sum  = int2bcd(t % MODV);
        e.cout = (t >= MODV);
        e.err  = has_invalid(av) | has_invalid(bv);
        exp_q.push_back(e);
    endtask

    // Follows one accepted operation: NDIG busy cycles, then the done cycle and the scoreboard pop.
    task automatic check_op(input string tag, input bit release_start, input bit poke);
        exp_t e;
        for (int k = 0; k < NDIG; k++) begin
            @(negedge clk);
            if (k == 0 && release_start) start = 1'b0;
            if (poke && k == 1) start = 1'b1;
            if (poke && k == 2) start = 1'b0;
            chk({tag, "_busy"}, W'(busy), W'(1));
            chk({tag, "_nodone"}, W'(done), W'(0));
        end
        @(negedge clk);
        chk({tag, "_done"}, W'(done), W'(1));
        chk({tag, "_idle"}, W'(busy), W'(0));
        checks++;
        assert (exp_q.size() != 0) else begin
            failures++;
            $error("FAIL %s_queue: observed=empty expected=entry", tag);
        end
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk({tag, "_err"}, W'(err), W'(e.err));
            if (!e.err) begin
                chk({tag, "_sum"}, sum, e.sum);
                chk({tag, "_cout"}, W'(cout), W'(e.cout));
            end
        end
    endtask

    initial begin
        bit seen_done;

        #2;
        chk("rst_busy", W'(busy), W'(0));
        chk("rst_done", W'(done), W'(0));
        chk("rst_sum", sum, W'(0));
        chk("rst_cout", W'(cout), W'(0));
        chk("rst_err", W'(err), W'(0));
        @(negedge clk);
        rst_n = 1'b1;

        launch(16'h1234, 16'h5678, 1'b0, 1'b0);
        check_op("add_1234_5678", 1'b1, 1'b0);
        chk("add_1234_5678_sumhex", sum, 16'h6912);

        launch(16'h9999, 16'h0001, 1'b0, 1'b0);
        check_op("add_9999_0001", 1'b1, 1'b0);

        launch(16'h0000, 16'h0000, 1'b1, 1'b0);
        check_op("add_cin_only", 1'b1, 1'b0);

        launch(16'h4567, 16'h5433, 1'b1, 1'b0);
        check_op("add_ripple_cin", 1'b1, 1'b0);

        launch(16'h00A0, 16'h0000, 1'b0, 1'b0);
        check_op("err_00a0", 1'b1, 1'b0);

        launch(16'h2468, 16'h1357, 1'b0, 1'b0);
        check_op("poke_busy", 1'b1, 1'b1);
        @(negedge clk);
        chk("poke_single_done", W'(done), W'(0));
        chk("poke_no_restart", W'(busy), W'(0));

        // Start held through DONE: the next operation is accepted without an IDLE cycle.
        launch(16'h0815, 16'h4711, 1'b0, 1'b0);
        check_op("b2b_first", 1'b0, 1'b0);
        a = 16'h9000;
        b = 16'h1000;
        cin = 1'b0;
        exp_q.push_back('{sum: 16'h0000, cout: 1'b1, err: 1'b0});
        check_op("b2b_second", 1'b1, 1'b0);

        launch(16'h0B99, 16'h0001, 1'b0, 1'b0);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("abort_busy_before", W'(busy), W'(1));
        rst_n = 1'b0;
        #1;
        chk("abort_busy", W'(busy), W'(0));
        chk("abort_done", W'(done), W'(0));
        chk("abort_sum", sum, W'(0));
        chk("abort_cout", W'(cout), W'(0));
        chk("abort_err", W'(err), W'(0));
        void'(exp_q.pop_back());
        @(negedge clk);
        rst_n = 1'b1;
        seen_done = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            seen_done = seen_done | done | busy;
        end
        chk("abort_no_done", W'(seen_done), W'(0));

`ifdef BCD_SUB_EN
        launch(16'h0500, 16'h0123, 1'b0, 1'b1);
        check_op("sub_0500_0123", 1'b1, 1'b0);
        launch(16'h0123, 16'h0500, 1'b0, 1'b1);
        check_op("sub_0123_0500", 1'b1, 1'b0);
        launch(16'h0042, 16'h0042, 1'b0, 1'b1);
        check_op("sub_equal", 1'b1, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
